multicycle_alu: RTL and testbench

//  Parametrised, registered successor of the single-cycle execute ALU. Adds SRA, SLTU, MUL (low

---
 rtl/multicycle_alu_pkg.sv | 36 +++
 rtl/multicycle_alu_if.sv | 30 +++
 rtl/multicycle_alu_iter_muldiv.sv | 94 +++++++++
 rtl/multicycle_alu.sv | 108 ++++++++++
 tb/tb_multicycle_alu.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared types for the multicycle execute ALU: datapath width, operation codes,
// FSM state encoding and the shift-amount helper.
package multicycle_alu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0] DataPath;

    typedef enum logic [3:0] {
        ALU_CODE_ADD  = 4'd0,
        ALU_CODE_SUB  = 4'd1,
        ALU_CODE_AND  = 4'd2,
        ALU_CODE_OR   = 4'd3,
        ALU_CODE_XOR  = 4'd4,
        ALU_CODE_SLT  = 4'd5,
        ALU_CODE_SLL  = 4'd6,
        ALU_CODE_SRL  = 4'd7,
        ALU_CODE_SRA  = 4'd8,
        ALU_CODE_SLTU = 4'd9,
        ALU_CODE_MUL  = 4'd10,
        ALU_CODE_DIVU = 4'd11,
        ALU_CODE_REMU = 4'd12
    } ALUCodePath;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } ALUStateType;

    function automatic logic [SHIFT_WIDTH-1:0] GET_SHIFT(input DataPath b);
        return b[SHIFT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand/result bus of the multicycle ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface multicycle_alu_if
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    logic                  inValid;
    logic                  inReady;
    ALUCodePath            code;
    logic [DATA_WIDTH-1:0] inA;
    logic [DATA_WIDTH-1:0] inB;
    logic                  flush;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] aluOut;

    modport master (
        output inValid, code, inA, inB, flush, outReady,
        input  inReady, outValid, aluOut
    );

    modport slave (
        input  inValid, code, inA, inB, flush, outReady,
        output inReady, outValid, aluOut
    );

endinterface

// File: rtl/multicycle_alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one set of shift registers.
// The first step is taken on the start edge, so DATA_WIDTH steps finish DATA_WIDTH-1 cycles later.
module alu_iter_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_is_div,
    input  logic                  i_want_rem,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic                  r_busy;
    logic                  r_is_div;
    logic                  r_want_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    logic                  w_is_div;
    logic [DATA_WIDTH-1:0] w_cur_acc;
    logic [DATA_WIDTH-1:0] w_cur_a;
    logic [DATA_WIDTH-1:0] w_cur_b;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_nxt_acc;
    logic [DATA_WIDTH-1:0] w_nxt_a;
    logic [DATA_WIDTH-1:0] w_nxt_b;

    // MUL: acc += a when b[0]; a shifts left, b shifts right.
    // DIV: acc is the partial remainder, a holds dividend bits going out and quotient bits coming in.
    always_comb begin
        w_is_div  = i_start ? i_is_div : r_is_div;
        w_cur_acc = i_start ? '0 : r_acc;
        w_cur_a   = i_start ? i_a : r_a;
        w_cur_b   = i_start ? i_b : r_b;
        w_shift   = {w_cur_acc, w_cur_a[DATA_WIDTH-1]};
        w_diff    = w_shift - {1'b0, w_cur_b};
        w_ge      = ~w_diff[DATA_WIDTH];
        if (w_is_div) begin
            w_nxt_acc = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
            w_nxt_a   = {w_cur_a[DATA_WIDTH-2:0], w_ge};
            w_nxt_b   = w_cur_b;
        end else begin
            w_nxt_acc = w_cur_acc + (w_cur_b[0] ? w_cur_a : '0);
            w_nxt_a   = w_cur_a << 1;
            w_nxt_b   = w_cur_b >> 1;
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_busy & (r_cnt == '0);
    assign o_result = (r_is_div & ~r_want_rem) ? w_nxt_a : w_nxt_acc;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_busy     <= 1'b0;
            r_is_div   <= 1'b0;
            r_want_rem <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_is_div   <= i_is_div;
            r_want_rem <= i_want_rem;
            r_cnt      <= CNT_W'(DATA_WIDTH - 2);
            r_acc      <= w_nxt_acc;
            r_a        <= w_nxt_a;
            r_b        <= w_nxt_b;
        end else if (r_busy) begin
            r_acc <= w_nxt_acc;
            r_a   <= w_nxt_a;
            r_b   <= w_nxt_b;
            if (r_cnt == '0) r_busy <= 1'b0;
            else             r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU: single-cycle ops complete in one cycle, MUL/DIVU/REMU run
// iteratively; valid/ready on both sides lets the core stall while a long op is busy.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = multicycle_alu_pkg::DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstN,
    multicycle_alu_if.slave      bus,
    output ALUStateType          o_dbg_state
);

    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

    ALUStateType           r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_alu_out;

    logic                   w_fire;
    logic                   w_is_mul;
    logic                   w_is_divop;
    logic                   w_start;
    logic                   w_single;
    logic [SHIFT_WIDTH-1:0] w_shamt;
    logic [DATA_WIDTH-1:0]  w_sra;
    logic [DATA_WIDTH-1:0]  w_single_res;
    logic                   w_busy;
    logic                   w_done;
    logic [DATA_WIDTH-1:0]  w_iter_res;

    assign bus.inReady  = (r_state == IDLE) & (~r_out_valid | bus.outReady) & ~bus.flush;
    assign bus.outValid = r_out_valid;
    assign bus.aluOut   = r_alu_out;
    assign o_dbg_state  = r_state;

    assign w_fire     = bus.inValid & bus.inReady;
    assign w_is_mul   = (bus.code == ALU_CODE_MUL);
    assign w_is_divop = (bus.code == ALU_CODE_DIVU) | (bus.code == ALU_CODE_REMU);
    // Divide-by-zero never enters the iterator; its fixed result is produced like a single-cycle op.
    assign w_start    = w_fire & (w_is_mul | (w_is_divop & (bus.inB != '0)));
    assign w_single   = w_fire & ~w_start;
    assign w_shamt    = bus.inB[SHIFT_WIDTH-1:0];
    assign w_sra      = $signed(bus.inA) >>> w_shamt;

    always_comb begin
        w_single_res = '0;
        case (bus.code)
            ALU_CODE_ADD:  w_single_res = bus.inA + bus.inB;
            ALU_CODE_SUB:  w_single_res = bus.inA - bus.inB;
            ALU_CODE_AND:  w_single_res = bus.inA & bus.inB;
            ALU_CODE_OR:   w_single_res = bus.inA | bus.inB;
            ALU_CODE_XOR:  w_single_res = bus.inA ^ bus.inB;
            ALU_CODE_SLT:  w_single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.inA) < $signed(bus.inB))};
            ALU_CODE_SLTU: w_single_res = {{(DATA_WIDTH-1){1'b0}}, (bus.inA < bus.inB)};
            ALU_CODE_SLL:  w_single_res = bus.inA << w_shamt;
            ALU_CODE_SRL:  w_single_res = bus.inA >> w_shamt;
            ALU_CODE_SRA:  w_single_res = w_sra;
            ALU_CODE_DIVU: w_single_res = '1;
            ALU_CODE_REMU: w_single_res = bus.inA;
            default:       w_single_res = '0;
        endcase
    end

    alu_iter_muldiv #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk        (clk),
        .rstN       (rstN),
        .i_start    (w_start),
        .i_abort    (bus.flush),
        .i_is_div   (~w_is_mul),
        .i_want_rem (bus.code == ALU_CODE_REMU),
        .i_a        (bus.inA),
        .i_b        (bus.inB),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_result   (w_iter_res)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE:     if (w_start) r_state <= w_is_mul ? MUL : DIV;
                MUL, DIV: if (w_done || !w_busy) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
            // A new result may land on the same edge the previous one is consumed.
            if (w_single) begin
                r_out_valid <= 1'b1;
                r_alu_out   <= w_single_res;
            end else if (w_done) begin
                r_out_valid <= 1'b1;
                r_alu_out   <= w_iter_res;
            end else if (bus.outReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (DATA_WIDTH=32): single-cycle table, iterative
// latency and results, result stall, flush and asynchronous reset mid-operation.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk;
    logic        rstN;
    ALUStateType dbg_state;
    int          n_total;
    int          n_bad;
    logic [31:0] exp_q[$];

    multicycle_alu_if #(.DATA_WIDTH(32)) bus ();

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ALUCodePath c, input logic [31:0] a, input logic [31:0] b);
        bus.inValid = 1'b1;
        bus.code    = c;
        bus.inA     = a;
        bus.inB     = b;
        #1;
    endtask

    task automatic run_iter(input string tag, input ALUCodePath c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input ALUStateType st);
        int lat;
        bit busy_ok;
        bus.outReady = 1'b0;
        drive(c, a, b);
        check({tag, " ready"}, 32'(bus.inReady), 32'd1);
        step();
        bus.inValid = 1'b0;
        check({tag, " state"}, 32'(dbg_state), 32'(st));
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.outValid && lat < 40) begin
            if (bus.inReady) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd32);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " result"}, bus.aluOut, exp);
        check({tag, " hold_ready"}, 32'(bus.inReady), 32'd0);
        bus.outReady = 1'b1;
        step();
        check({tag, " drained"}, 32'(bus.outValid), 32'd0);
    endtask

    ALUCodePath  t_code[15];
    logic [31:0] t_a[15];
    logic [31:0] t_b[15];
    logic [31:0] t_exp[15];

    initial begin
        bit quiet;
        n_total = 0;
        n_bad   = 0;
        t_code = '{ALU_CODE_ADD, ALU_CODE_SLT, ALU_CODE_SLTU, ALU_CODE_SRA, ALU_CODE_SRL,
                   ALU_CODE_SLL, ALU_CODE_SUB, ALU_CODE_AND, ALU_CODE_OR, ALU_CODE_XOR,
                   ALU_CODE_SLT, ALU_CODE_SLTU, ALUCodePath'(4'hF), ALU_CODE_DIVU, ALU_CODE_REMU};
        t_a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                  32'h00000001, 32'h00000003, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0,
                  32'h00000001, 32'h00000001, 32'h00000005, 32'h00000005, 32'h00000005};
        t_b   = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000021, 32'h00000021,
                  32'h0000001F, 32'h00000005, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h00000000, 32'h00000000};
        t_exp = '{32'h00000000, 32'h00000001, 32'h00000000, 32'hC0000000, 32'h40000000,
                  32'h80000000, 32'hFFFFFFFE, 32'h0000F000, 32'h0000FFF0, 32'h00000FF0,
                  32'h00000000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000005};

        // Clock/reset
        rstN         = 1'b0;
        bus.inValid  = 1'b0;
        bus.code     = ALU_CODE_ADD;
        bus.inA      = '0;
        bus.inB      = '0;
        bus.flush    = 1'b0;
        bus.outReady = 1'b1;
        step();
        step();
        check("reset out_valid", 32'(bus.outValid), 32'd0);
        check("reset alu_out", bus.aluOut, 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        rstN = 1'b1;
        step();

        // Back-to-back single-cycle table, one result per cycle
        for (int i = 0; i < 15; i++) begin
            drive(t_code[i], t_a[i], t_b[i]);
            check($sformatf("table%0d ready", i), 32'(bus.inReady), 32'd1);
            exp_q.push_back(t_exp[i]);
            step();
            check($sformatf("table%0d valid", i), 32'(bus.outValid), 32'd1);
            check($sformatf("table%0d result", i), bus.aluOut, exp_q.pop_front());
        end
        bus.inValid = 1'b0;
        step();
        check("table drained", 32'(bus.outValid), 32'd0);

        // Iterative ops
        run_iter("mul_10001", ALU_CODE_MUL, 32'h00010001, 32'h00010001, 32'h00020001, MUL);
        run_iter("mul_ones", ALU_CODE_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL);
        run_iter("mul_zero", ALU_CODE_MUL, 32'h12345678, 32'h00000000, 32'h00000000, MUL);
        run_iter("divu_100_7", ALU_CODE_DIVU, 32'd100, 32'd7, 32'd14, DIV);
        run_iter("remu_100_7", ALU_CODE_REMU, 32'd100, 32'd7, 32'd2, DIV);
        run_iter("remu_7_100", ALU_CODE_REMU, 32'd7, 32'd100, 32'd7, DIV);
        run_iter("divu_big_1", ALU_CODE_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, DIV);
        run_iter("divu_msb_3", ALU_CODE_DIVU, 32'h80000000, 32'd3, 32'h2AAAAAAA, DIV);
        run_iter("remu_msb_3", ALU_CODE_REMU, 32'h80000000, 32'd3, 32'd2, DIV);

        // Result stall: next op waits, accepted the cycle outReady rises
        bus.outReady = 1'b0;
        drive(ALU_CODE_ADD, 32'd7, 32'd8);
        step();
        drive(ALU_CODE_SUB, 32'd9, 32'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d result", k), bus.aluOut, 32'd15);
            check($sformatf("stall%0d valid", k), 32'(bus.outValid), 32'd1);
            check($sformatf("stall%0d ready", k), 32'(bus.inReady), 32'd0);
            step();
        end
        bus.outReady = 1'b1;
        #1;
        check("stall release ready", 32'(bus.inReady), 32'd1);
        step();
        bus.inValid = 1'b0;
        check("stall next result", bus.aluOut, 32'd5);
        check("stall next valid", 32'(bus.outValid), 32'd1);
        step();

        // Flush drops a held result and accepts nothing that cycle
        bus.outReady = 1'b0;
        drive(ALU_CODE_ADD, 32'd1, 32'd1);
        step();
        check("held before flush", 32'(bus.outValid), 32'd1);
        drive(ALU_CODE_SUB, 32'd9, 32'd4);
        bus.outReady = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("flush ready", 32'(bus.inReady), 32'd0);
        step();
        bus.flush = 1'b0;
        bus.inValid = 1'b0;
        check("flush drops result", 32'(bus.outValid), 32'd0);
        step();
        check("flush nothing accepted", 32'(bus.outValid), 32'd0);

        // Flush at MUL iteration 10
        drive(ALU_CODE_MUL, 32'h00010001, 32'h00010001);
        step();
        bus.inValid = 1'b0;
        for (int k = 0; k < 9; k++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("mul flush state", 32'(dbg_state), 32'(IDLE));
        check("mul flush valid", 32'(bus.outValid), 32'd0);
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.outValid) quiet = 1'b0;
            step();
        end
        check("mul flush no ghost", 32'(quiet), 32'd1);
        drive(ALU_CODE_ADD, 32'd2, 32'd3);
        step();
        bus.inValid = 1'b0;
        check("after flush add", bus.aluOut, 32'd5);
        check("after flush valid", 32'(bus.outValid), 32'd1);
        step();

        // Asynchronous reset mid-DIV
        drive(ALU_CODE_DIVU, 32'd100, 32'd7);
        step();
        bus.inValid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rstN = 1'b0;
        #1;
        check("div reset state", 32'(dbg_state), 32'(IDLE));
        check("div reset valid", 32'(bus.outValid), 32'd0);
        check("div reset alu_out", bus.aluOut, 32'd0);
        step();
        rstN = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.outValid) quiet = 1'b0;
            step();
        end
        check("div reset no ghost", 32'(quiet), 32'd1);
        drive(ALU_CODE_ADD, 32'd2, 32'd3);
        step();
        bus.inValid = 1'b0;
        check("after reset add", bus.aluOut, 32'd5);
        check("after reset valid", 32'(bus.outValid), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
